axil_rd_resp: RTL and testbench
===============================

# axil_rd_resp

AXI4-Lite read-channel responder in front of a local word array. It accepts read addresses on the AR channel, waits a configurable latency, and returns data and a response code on the R channel. A simple enable-qualified write port fills the array. The NPC memory path uses it as the read end of the data-memory model, so fetch/LSU initiators see realistic handshakes and delays.

## Interface
- ADDR_W, 32, AR address width (bits)
- DATA_W, 32, data width; fixed at 32 (4-byte words)
- DEPTH, 256, number of words in the array (power of two)
- LAT, 1, base read latency in cycles from AR handshake to first rvalid cycle; legal 1..15
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- araddr  in  ADDR_W  byte address
- rvalid  out  1  read data valid
- rready  in  1  read data accepted
- rdata  out  DATA_W  read data
- rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
- wen  in  1  array write enable
- waddr  in  log2(DEPTH)  word index for write
- wdata  in  DATA_W  write data

## Operation
- FSM states: IDLE, WAIT, RESP. Reset enters IDLE.
- IDLE: arready=1. On arvalid&&arready, latch araddr, load the delay counter with LAT-1 (+extra, see Configuration), and go to WAIT.
- WAIT: arready=0. Decrement the counter each cycle. When it reaches 0, capture rdata/rresp and go to RESP, with rvalid=1 from the next cycle.
- RESP: rvalid=1. rdata and rresp hold stable until rready. On rvalid&&rready, go to IDLE; arready=1 the following cycle.
- No AR/R overlap: at most one outstanding transaction. Minimum period is LAT+2 cycles per read with rready tied high.
- Decode, checked in priority order:
  - araddr[1:0]!=0 → rresp=10, rdata=0.
  - araddr[ADDR_W-1:2]>=DEPTH → rresp=11, rdata=0.
  - Otherwise rresp=00, rdata=mem[araddr[ADDR_W-1:2]].
- Write port is independent of FSM state. On a rising edge with wen=1, mem[waddr]<=wdata.
- Read/write collision: the array is sampled on the edge that moves WAIT→RESP. A write on that same edge is not visible (old data returned). A write on any earlier edge is visible.
- Array contents are not reset.

## Timing
- Reset values: arready=0 while rst low; rvalid=0, rdata=0, rresp=00. arready rises in the first cycle after rst deasserts.
- AR handshake at edge N, LAT=1, no extra delay → rvalid high in cycle N+1, before edge N+2.
- rvalid never drops without rready. rdata and rresp do not change while rvalid=1.
- rst asserted mid-transaction (WAIT or RESP) → immediate return to IDLE, rvalid=0, pending read discarded, no response issued.
- arvalid may stay high across RESP. It is not accepted until IDLE.

## Configuration
- RAND_DELAY_EN defined:
  - An 8-bit LFSR (seed 8'hA5 at reset) advances every cycle.
  - On each AR handshake, LFSR[2:0] (0..7) is added to the counter load, so latency is LAT..LAT+7.
  - The LFSR is reset by rst.
- RAND_DELAY_EN undefined: the LFSR is not built, and latency is exactly LAT.

## Structure
- Shared package: FSM state encoding, response constants (RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11), LFSR seed.
- One sub-module: lfsr8 (8-bit Fibonacci, taps 8,6,5,4, async active-low reset, seed parameter). It is instantiated only under RAND_DELAY_EN.

## Test plan
- Reset then idle: hold rst low 3 cycles → arready=0, rvalid=0, rdata=0, rresp=00. One cycle after release, arready=1.
- Basic read, LAT=1, RAND_DELAY_EN undefined:
  - Write mem[4]=32'hDEADBEEF, then AR araddr=32'h10 with rready=1.
  - rvalid exactly 1 cycle after handshake, rdata=32'hDEADBEEF, rresp=00. arready=1 the cycle after R handshake.
- Backpressure, LAT=3:
  - AR araddr=32'h0 with mem[0]=32'h1234, rready=0 for 5 cycles after rvalid rises.
  - rvalid and rdata=32'h1234 stable all 5 cycles. arready=0 throughout. Completes on rready=1.
- Errors:
  - araddr=32'h6 → rresp=10, rdata=0.
  - araddr=32'h400 (DEPTH=256) → rresp=11, rdata=0.
  - Both still complete the full handshake.
- Collision, LAT=2:
  - mem[1]=32'hA, AR araddr=32'h4, wen to mem[1]=32'hB on the WAIT→RESP edge → rdata=32'hA.
  - Repeat with the write one edge earlier → rdata=32'hB.
- Reset mid-WAIT, with RAND_DELAY_EN defined:
  - Pulse rst low during WAIT → rvalid never asserts, FSM returns to IDLE.
  - 50 subsequent reads each have latency in LAT..LAT+7, and the latency sequence repeats identically after a second reset.

Source files
------------

// File: rtl/axil_rd_resp_pkg.sv
// Shared types and constants for the AXI4-Lite read responder.
// Optional feature macro: RAND_DELAY_EN (adds 0..7 cycles of LFSR-driven latency).
package axil_rd_resp_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // Wide enough for LAT-1 (max 14) plus the random extra (max 7).
  localparam int CNT_W = 5;

endpackage

// File: rtl/axil_rd_resp_lfsr8.sv
// 8-bit Fibonacci LFSR, taps 8,6,5,4, free-running, seeded on reset.
// Only instantiated when RAND_DELAY_EN is defined.
module lfsr8
  import axil_rd_resp_pkg::*;
#(
  parameter logic [7:0] SEED = LFSR_SEED
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] q
);

  // Shift left, feeding back the XOR of taps 8,6,5,4.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= SEED;
    else      q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  end

endmodule

// File: rtl/axil_rd_resp.sv
// AXI4-Lite read-channel responder over a local word array with a
// configurable response latency and a side write port for filling the array.
// Optional feature macro: RAND_DELAY_EN (latency becomes LAT..LAT+7).
module axil_rd_resp
  import axil_rd_resp_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int LAT    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arvalid,
  output logic                     arready,
  input  logic [ADDR_W-1:0]        araddr,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [DATA_W-1:0]        rdata,
  output logic [1:0]               rresp,
  input  logic                     wen,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        extra;
  logic [CNT_W-1:0]  cnt_load;
  logic [ADDR_W-3:0] word;
  logic              misalign;
  logic              oor;

`ifdef RAND_DELAY_EN
  logic [7:0] lfsr_q;
  logic       unused_lfsr;

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  assign extra       = lfsr_q[2:0];
  assign unused_lfsr = ^lfsr_q[7:3];
`else
  assign extra = 3'd0;
`endif

  // Counter counts down to zero; zero in WAIT is the sampling edge.
  assign cnt_load = CNT_W'(LAT - 1) + CNT_W'(extra);

  // Decode of the latched address: misalignment wins over range.
  assign word     = addr_q[ADDR_W-1:2];
  assign misalign = (addr_q[1:0] != 2'b00);
  assign oor      = ({2'b00, word} >= ADDR_W'(DEPTH));

  // Array write port, independent of the read FSM; contents not reset.
  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
  end

  // Single-outstanding read FSM with registered handshake outputs.
  // The array read uses pre-edge contents, so a same-edge write is not seen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
      addr_q  <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (arvalid && arready) begin
            addr_q  <= araddr;
            cnt     <= cnt_load;
            arready <= 1'b0;
            state   <= S_WAIT;
          end else begin
            arready <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            rvalid <= 1'b1;
            state  <= S_RESP;
            if (misalign) begin
              rresp <= RESP_SLVERR;
              rdata <= '0;
            end else if (oor) begin
              rresp <= RESP_DECERR;
              rdata <= '0;
            end else begin
              rresp <= RESP_OKAY;
              rdata <= mem[word[IDX_W-1:0]];
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (rready) begin
            rvalid  <= 1'b0;
            arready <= 1'b1;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_rd_resp.sv
// Self-checking bench for axil_rd_resp: transaction-level reference model
// checked every cycle, plus directed reads with literal expectations.
module tb_axil_rd_resp;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;
  localparam int LAT    = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              arvalid = 1'b0;
  logic              arready;
  logic [ADDR_W-1:0] araddr = '0;
  logic              rvalid;
  logic              rready = 1'b0;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              wen = 1'b0;
  logic [7:0]        waddr = '0;
  logic [DATA_W-1:0] wdata = '0;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axil_rd_resp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .wen(wen), .waddr(waddr), .wdata(wdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [31:0] mmem [DEPTH];
  bit          m_arready = 0;
  bit          m_rvalid  = 0;
  bit          m_busy    = 0;
  int          m_left    = 0;
  logic [31:0] m_addr    = '0;
  logic [31:0] m_rdata   = '0;
  logic [1:0]  m_rresp   = 2'b00;
  logic [7:0]  m_lfsr    = 8'hA5;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_arready = 0; m_rvalid = 0; m_busy = 0; m_left = 0;
      m_rdata = '0; m_rresp = 2'b00; m_lfsr = 8'hA5;
    end else begin
      if (m_rvalid) begin
        if (rready) begin
          m_rvalid = 0; m_busy = 0; m_arready = 1;
        end
      end else if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_rvalid = 1;
          if (m_addr[1:0] != 2'b00) begin
            m_rresp = 2'b10; m_rdata = '0;
          end else if ((m_addr >> 2) >= DEPTH) begin
            m_rresp = 2'b11; m_rdata = '0;
          end else begin
            m_rresp = 2'b00; m_rdata = mmem[m_addr[9:2]];
          end
        end
      end else if (m_arready && arvalid) begin
        m_busy = 1; m_arready = 0; m_addr = araddr;
`ifdef RAND_DELAY_EN
        m_left = LAT + int'(m_lfsr[2:0]);
`else
        m_left = LAT;
`endif
      end else begin
        m_arready = 1;
      end
      if (wen) mmem[waddr] = wdata;
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_arready", {31'd0, arready}, 32'd0);
      chk("rst_rvalid",  {31'd0, rvalid},  32'd0);
      chk("rst_rdata",   rdata,            32'd0);
      chk("rst_rresp",   {30'd0, rresp},   32'd0);
    end else begin
      chk("m_arready", {31'd0, arready}, {31'd0, m_arready});
      chk("m_rvalid",  {31'd0, rvalid},  {31'd0, m_rvalid});
      if (m_rvalid) begin
        chk("m_rdata", rdata,          m_rdata);
        chk("m_rresp", {30'd0, rresp}, {30'd0, m_rresp});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) tick();
    chk("lit_rst_arready", {31'd0, arready}, 32'd0);
    chk("lit_rst_rvalid",  {31'd0, rvalid},  32'd0);
    chk("lit_rst_rdata",   rdata,            32'd0);
    chk("lit_rst_rresp",   {30'd0, rresp},   32'd0);
    rst = 1'b1;
    tick();
    chk("lit_arready_after_rst", {31'd0, arready}, 32'd1);
  endtask

  task automatic wr(input logic [7:0] idx, input logic [31:0] d);
    wen = 1'b1; waddr = idx; wdata = d;
    tick();
    wen = 1'b0;
  endtask

  // One full read. arvalid stays high through WAIT/RESP to confirm it is
  // not re-accepted. wr_at = edge index after the handshake on which a
  // side write is issued (0 = none).
  task automatic rd(input logic [31:0] a, input int bp, input int wr_at,
                    input logic [7:0] widx, input logic [31:0] wd,
                    input logic [31:0] exp_d, input logic [1:0] exp_r,
                    output int lat);
    int n;
    araddr = a; arvalid = 1'b1; rready = (bp == 0);
    n = 0;
    while (!arready && n < 20) begin tick(); n++; end
    chk("ar_wait", {31'd0, arready}, 32'd1);
    tick();
    lat = 0;
    while (!rvalid && lat < 40) begin
      if (lat + 1 == wr_at) begin wen = 1'b1; waddr = widx; wdata = wd; end
      tick();
      wen = 1'b0;
      lat++;
    end
    chk("r_timeout", {31'd0, rvalid}, 32'd1);
    chk("lit_rdata", rdata, exp_d);
    chk("lit_rresp", {30'd0, rresp}, {30'd0, exp_r});
    for (int i = 0; i < bp; i++) begin
      tick();
      chk("bp_rvalid",  {31'd0, rvalid},  32'd1);
      chk("bp_rdata",   rdata,            exp_d);
      chk("bp_arready", {31'd0, arready}, 32'd0);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0; arvalid = 1'b0;
    chk("post_r_arready", {31'd0, arready}, 32'd1);
    chk("post_r_rvalid",  {31'd0, rvalid},  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    do_reset();

`ifndef RAND_DELAY_EN
    wr(8'd4, 32'hDEADBEEF);
    wr(8'd0, 32'h00001234);
    wr(8'd1, 32'h0000000A);
    wr(8'd255, 32'hCAFE0255);

    // Basic read: latency exactly LAT.
    rd(32'h10, 0, 0, 8'd0, 32'd0, 32'hDEADBEEF, 2'b00, lat);
    chk("lat_basic", lat, LAT);

    // Backpressure: 5 cycles of rready low.
    rd(32'h0, 5, 0, 8'd0, 32'd0, 32'h00001234, 2'b00, lat);
    chk("lat_bp", lat, LAT);

    // Error decodes and the last legal word.
    rd(32'h6,   0, 0, 8'd0, 32'd0, 32'h0, 2'b10, lat);
    rd(32'h400, 0, 0, 8'd0, 32'd0, 32'h0, 2'b11, lat);
    rd(32'h3FC, 0, 0, 8'd0, 32'd0, 32'hCAFE0255, 2'b00, lat);

    // Collision: write on the sampling edge is not seen, one edge earlier is.
    rd(32'h4, 0, LAT,     8'd1, 32'h0000000B, 32'h0000000A, 2'b00, lat);
    wr(8'd1, 32'h0000000A);
    rd(32'h4, 0, LAT - 1, 8'd1, 32'h0000000B, 32'h0000000B, 2'b00, lat);

    // Reset during WAIT: response discarded.
    araddr = 32'h10; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    rst = 1'b0;
    chk("midwait_rvalid", {31'd0, rvalid}, 32'd0);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("midwait_arready", {31'd0, arready}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("midwait_no_rvalid", {31'd0, rvalid}, 32'd0);
    end

    // Recovery read after the aborted transaction.
    rd(32'h10, 0, 0, 8'd0, 32'd0, 32'hDEADBEEF, 2'b00, lat);
    chk("lat_recover", lat, LAT);
`else
    begin
      int lat1 [50];
      wr(8'd0, 32'h00001234);
      rd(32'h6, 0, 0, 8'd0, 32'd0, 32'h0, 2'b10, lat);
      rd(32'h400, 0, 0, 8'd0, 32'd0, 32'h0, 2'b11, lat);

      // Reset during WAIT.
      araddr = 32'h0; arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      rst = 1'b0;
      chk("midwait_rvalid", {31'd0, rvalid}, 32'd0);
      tick();
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
        tick();
        chk("midwait_no_rvalid", {31'd0, rvalid}, 32'd0);
      end

      do_reset();
      wr(8'd0, 32'h00001234);
      for (int i = 0; i < 50; i++) begin
        rd(32'h0, 0, 0, 8'd0, 32'd0, 32'h00001234, 2'b00, lat);
        lat1[i] = lat;
        chk("lat_range", {31'd0, (lat >= LAT && lat <= LAT + 7)}, 32'd1);
      end
      do_reset();
      wr(8'd0, 32'h00001234);
      for (int i = 0; i < 50; i++) begin
        rd(32'h0, 0, 0, 8'd0, 32'd0, 32'h00001234, 2'b00, lat);
        chk("lat_repeat", lat, lat1[i]);
      end
    end
`endif

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
